axis_pkt_check: RTL and testbench
=================================

# axis_pkt_check

Downstream sink for the LFSR stimulus stream in the fv_enc datapath. Accepts an `axis_if` stream, drives `rdy` with an optional deterministic backpressure pattern, and checks that every packet is exactly N beats long. Produces per-packet checksums and saturating packet and error counters for the bench and the on-chip status readout.

## Interface
- `N`, 16: expected beats per packet, `last` on beat N; N ≥ 2.
- `DATAW`, 64: stream data width.
- `STALL_PERIOD`, 4: with stalls enabled, `rdy` is low for 1 cycle out of every STALL_PERIOD; STALL_PERIOD ≥ 2.
- `CNTW`, 16: width of the status counters.

- `clk`  in  1  clock.
- `s_rst_n`  in  1  synchronous reset, active-low.
- `s_axis`  `axis_if.in`  —  input stream: `data[DATAW]`, `vld`, `last` in; `rdy` out.
- `stall_en`  in  1  enables the backpressure pattern on `rdy`.
- `pkt_cnt`  out  CNTW  packets completed, saturating.
- `len_err_cnt`  out  CNTW  packets with a length error, saturating.
- `checksum`  out  DATAW  checksum of the last completed packet.
- `checksum_vld`  out  1  one-cycle pulse when `checksum` updates.
- `busy`  out  1  high while a packet is open (≥1 beat accepted, `last` not yet seen).

## Operation
- Beat: a cycle with `vld && rdy` at the posedge. Nothing else changes checker state.
- Ready generation: free-running stall counter `sc` counts 0..STALL_PERIOD-1 and wraps.
  - With `stall_en`=1, `rdy` is registered and is low exactly when the next `sc`=STALL_PERIOD-1.
  - With `stall_en`=0, `rdy`=1.
  - `rdy` never depends combinationally on `vld`.
- Beat counter `bc` has width $clog2(N)+1 and counts beats of the open packet, saturating at N.
- States:
  - IDLE → OPEN on a non-last beat.
  - OPEN → IDLE on a `last` beat.
  - A `last` beat in IDLE is a complete one-beat packet.
- Length errors, flagged at most once per packet:
  - Short: `last` on beat k < N.
  - Long: beat N arrives without `last`. Flag it at beat N. Keep accepting beats until `last`.
  - Exact: `last` on beat N, no error.
- Packet end, on a `last` beat:
  - `pkt_cnt`++.
  - `len_err_cnt`++ if the packet was flagged.
  - `bc` and the error flag clear.
  - The accumulator value including this beat goes to `checksum`.
  - `checksum_vld` pulses.
- Checksum accumulator `acc`, DATAW bits, cleared at packet start. Default update: `acc ^= data`.
- Counters saturate at 2^CNTW−1. No wrap.

## Timing
- Reset values:
  - `rdy`=0, `pkt_cnt`=0, `len_err_cnt`=0, `checksum`=0, `checksum_vld`=0, `busy`=0.
  - Internally `sc`=0, `bc`=0, `acc`=0, state IDLE.
- `rdy` goes high on the first cycle after `s_rst_n` deasserts.
- Latency: counters, `checksum` and `checksum_vld` are registered. They update on the clock edge that accepts the `last` beat, so they are visible the following cycle. `checksum_vld` is high for exactly 1 cycle per packet.
- Back-to-back packets are allowed: `last` beat followed by the next packet's first beat on the next cycle. The accumulator restarts from 0 for the new beat, with no bubble.
- `vld` high while `rdy` is low is not a beat. The sink does not require `data` to be held. The protocol rule is the source's responsibility.
- Reset mid-packet: the open packet is discarded and never counted. The first beat after reset starts a new packet.
- `stall_en` changes take effect on the next `rdy` register update. `sc` keeps running regardless.

## Configuration
- `AXIS_CHK_ROTATE_EN`
  - Defined: `acc = {acc[DATAW-2:0], acc[DATAW-1]} ^ data`, i.e. rotate-left-by-1 then XOR. The checksum is order-sensitive.
  - Undefined: plain XOR (`acc ^= data`), which is order-insensitive.
  - Nothing else changes.

## Test plan
- N=4, DATAW=8, `stall_en`=0. Send 01,02,04,08 with `last` on 08.
  - `checksum`=0F, `pkt_cnt`=1, `len_err_cnt`=0, one `checksum_vld` pulse.
  - With `AXIS_CHK_ROTATE_EN`: `checksum`=00.
- N=4. Send 3 beats AA,55,FF with `last` on the 3rd.
  - `len_err_cnt`=1, `pkt_cnt`=1, `checksum`=00 (XOR build).
- N=4. Send 6 beats with `last` on the 6th.
  - `len_err_cnt`=1, counted once only. `busy` stays high until the 6th beat.
- `stall_en`=1, STALL_PERIOD=4, `vld` held high.
  - `rdy` is low on exactly 1 of every 4 cycles.
  - 8 packets of N=4 give `pkt_cnt`=8 and `len_err_cnt`=0.
- Assert `s_rst_n`=0 after 2 beats of a packet, then send one full correct packet.
  - During reset all outputs are 0.
  - Afterwards `pkt_cnt`=1 and `len_err_cnt`=0.
- CNTW=4. Send 20 one-beat packets with N=2.
  - `pkt_cnt`=F and `len_err_cnt`=F, both saturated, with no wrap.

Source files
------------

// File: rtl/axis_pkt_check.sv
// axis_pkt_check: AXI-stream sink that checks N-beat packet length and builds per-packet checksums; define AXIS_CHK_ROTATE_EN for an order-sensitive rotate-XOR checksum
module axis_pkt_check #(
  parameter int N            = 16,
  parameter int DATAW        = 64,
  parameter int STALL_PERIOD = 4,
  parameter int CNTW         = 16
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic [DATAW-1:0] s_axis_data,
  input  logic             s_axis_vld,
  input  logic             s_axis_last,
  output logic             s_axis_rdy,
  input  logic             stall_en,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  len_err_cnt,
  output logic [DATAW-1:0] checksum,
  output logic             checksum_vld,
  output logic             busy
);
  localparam int BW = $clog2(N) + 1;
  localparam int SW = $clog2(STALL_PERIOD);
  localparam logic [BW-1:0] BN = BW'(N);
  localparam logic [SW-1:0] SL = SW'(STALL_PERIOD - 1);
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] sc, sc_nxt;
  logic [BW-1:0] bc;
  logic [DATAW-1:0] acc, acc_nxt;
  logic err, beat, bad;
  assign beat   = s_axis_vld && s_axis_rdy;
  assign sc_nxt = sc == SL ? '0 : sc + 1'b1;
  assign bad    = err || bc < BN - 1'b1;
`ifdef AXIS_CHK_ROTATE_EN
  assign acc_nxt = {acc[DATAW-2:0], acc[DATAW-1]} ^ s_axis_data;
`else
  assign acc_nxt = acc ^ s_axis_data;
`endif
  // packet open/closed state register
  always_ff @(posedge clk)
    state <= !s_rst_n ? IDLE : state_nxt;
  // next state follows each accepted beat; busy while a packet is open
  always_comb begin
    state_nxt = beat ? (s_axis_last ? IDLE : OPEN) : state;
    busy      = state == OPEN;
  end
  // free-running stall counter and registered ready, low when the next count is the last slot
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      sc         <= '0;
      s_axis_rdy <= 1'b0;
    end else begin
      sc         <= sc_nxt;
      s_axis_rdy <= !(stall_en && sc_nxt == SL);
    end
  end
  // beat counting, length-error flagging, checksum accumulation and saturating counters
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      bc           <= '0;
      err          <= 1'b0;
      acc          <= '0;
      pkt_cnt      <= '0;
      len_err_cnt  <= '0;
      checksum     <= '0;
      checksum_vld <= 1'b0;
    end else begin
      checksum_vld <= beat && s_axis_last;
      if (beat && s_axis_last) begin
        bc       <= '0;
        err      <= 1'b0;
        acc      <= '0;
        checksum <= acc_nxt;
        pkt_cnt  <= pkt_cnt == '1 ? pkt_cnt : pkt_cnt + 1'b1;
        if (bad) len_err_cnt <= len_err_cnt == '1 ? len_err_cnt : len_err_cnt + 1'b1;
      end else if (beat) begin
        acc <= acc_nxt;
        if (bc != BN) bc <= bc + 1'b1;
        if (bc == BN - 1'b1) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_pkt_check.sv
// tb_axis_pkt_check: directed table, corner sequences and randomized traffic against a queue-based packet model
module tb_axis_pkt_check;
  localparam int N = 4, DW = 8, SP = 4, CW = 4;
  localparam int CMAX = 2**CW - 1;
`ifdef AXIS_CHK_ROTATE_EN
  localparam logic [DW-1:0] CS1 = 8'h00, CS2 = 8'hFF, CS3 = 8'h44;
`else
  localparam logic [DW-1:0] CS1 = 8'h0F, CS2 = 8'h00, CS3 = 8'h77;
`endif
  logic clk = 0, s_rst_n = 0, vld = 0, last = 0, stall_en = 0;
  logic [DW-1:0] data = '0;
  logic rdy, csv, busy;
  logic [DW-1:0] cs;
  logic [CW-1:0] pkt, errc;
  int checks = 0, failures = 0;
  bit mchk = 0;
  always #5 clk = ~clk;
  axis_pkt_check #(.N(N), .DATAW(DW), .STALL_PERIOD(SP), .CNTW(CW)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .s_axis_data(data), .s_axis_vld(vld),
    .s_axis_last(last), .s_axis_rdy(rdy), .stall_en(stall_en), .pkt_cnt(pkt),
    .len_err_cnt(errc), .checksum(cs), .checksum_vld(csv), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // checksum of a whole packet, folded over its beats in arrival order
  function automatic logic [DW-1:0] fold(input logic [DW-1:0] q[$]);
    logic [DW-1:0] a = '0;
    foreach (q[i]) begin
`ifdef AXIS_CHK_ROTATE_EN
      a = {a[DW-2:0], a[DW-1]} ^ q[i];
`else
      a = a ^ q[i];
`endif
    end
    return a;
  endfunction
  int e = 0, m_pkt = 0, m_err = 0;
  logic m_rdy = 0, m_csv = 0;
  logic [DW-1:0] m_cs = '0;
  logic [DW-1:0] q[$];
  // reference model: collect beats of the open packet, judge the packet as a whole at last
  always @(posedge clk) begin
    if (!s_rst_n) begin
      e = 0; m_rdy = 0; q.delete(); m_pkt = 0; m_err = 0; m_cs = '0; m_csv = 0;
    end else begin
      m_csv = 0;
      if (vld && m_rdy) begin
        q.push_back(data);
        if (last) begin
          m_pkt = m_pkt < CMAX ? m_pkt + 1 : CMAX;
          if (q.size() != N) m_err = m_err < CMAX ? m_err + 1 : CMAX;
          m_cs = fold(q);
          m_csv = 1;
          q.delete();
        end
      end
      e++;
      m_rdy = !(stall_en && e % SP == SP - 1);
    end
  end
  always @(negedge clk) begin
    if (mchk) begin
      chk("model rdy", rdy, m_rdy);
      chk("model pkt_cnt", pkt, m_pkt);
      chk("model len_err_cnt", errc, m_err);
      chk("model checksum", cs, m_cs);
      chk("model checksum_vld", csv, m_csv);
      chk("model busy", busy, q.size() != 0);
    end
  end
  typedef struct {logic v; logic l; logic [DW-1:0] d; logic b; logic [CW-1:0] p; logic [CW-1:0] er; logic [DW-1:0] c; logic cv;} vec_t;
  vec_t tbl[$];
  task automatic add(input logic v, l, input logic [DW-1:0] d, input logic b, input logic [CW-1:0] p, er, input logic [DW-1:0] c, input logic cv);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.b = b; t.p = p; t.er = er; t.c = c; t.cv = cv;
    tbl.push_back(t);
  endtask
  task automatic do_reset();
    s_rst_n = 0;
    repeat (2) @(negedge clk);
    s_rst_n = 1;
    @(negedge clk);
  endtask
  initial begin
    int nb, cyc, lows;
    bit acc_b;
    add(1, 0, 8'h01, 1, 0, 0, 8'h00, 0);
    add(1, 0, 8'h02, 1, 0, 0, 8'h00, 0);
    add(1, 0, 8'h04, 1, 0, 0, 8'h00, 0);
    add(1, 1, 8'h08, 0, 1, 0, CS1, 1);
    add(1, 0, 8'hAA, 1, 1, 0, CS1, 0);
    add(1, 0, 8'h55, 1, 1, 0, CS1, 0);
    add(1, 1, 8'hFF, 0, 2, 1, CS2, 1);
    add(1, 0, 8'h11, 1, 2, 1, CS2, 0);
    add(1, 0, 8'h22, 1, 2, 1, CS2, 0);
    add(1, 0, 8'h33, 1, 2, 1, CS2, 0);
    add(1, 0, 8'h44, 1, 2, 1, CS2, 0);
    add(1, 0, 8'h55, 1, 2, 1, CS2, 0);
    add(1, 1, 8'h66, 0, 3, 2, CS3, 1);
    add(0, 0, 8'h00, 0, 3, 2, CS3, 0);
    do_reset();
    mchk = 1;
    foreach (tbl[i]) begin
      vld = tbl[i].v; last = tbl[i].l; data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
      chk($sformatf("vec%0d pkt_cnt", i), pkt, tbl[i].p);
      chk($sformatf("vec%0d len_err_cnt", i), errc, tbl[i].er);
      chk($sformatf("vec%0d checksum", i), cs, tbl[i].c);
      chk($sformatf("vec%0d checksum_vld", i), csv, tbl[i].cv);
    end
    vld = 0; last = 0;
    stall_en = 1;
    do_reset();
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (!rdy) lows++;
      @(negedge clk);
    end
    chk("stall rdy lows per 16", lows, 4);
    nb = 0; cyc = 0; vld = 1;
    while (nb < 8 * N && cyc < 200) begin
      last = nb % N == N - 1;
      data = DW'($urandom);
      acc_b = rdy;
      @(negedge clk);
      if (acc_b) nb++;
      cyc++;
    end
    vld = 0; last = 0;
    @(negedge clk);
    chk("stall beats accepted", nb, 8 * N);
    chk("stall pkt_cnt", pkt, 8);
    chk("stall len_err_cnt", errc, 0);
    stall_en = 0;
    do_reset();
    vld = 1; last = 1;
    repeat (20) begin
      data = DW'($urandom);
      @(negedge clk);
    end
    vld = 0; last = 0;
    @(negedge clk);
    chk("sat pkt_cnt", pkt, CMAX);
    chk("sat len_err_cnt", errc, CMAX);
    vld = 1;
    repeat (2) @(negedge clk);
    vld = 0;
    chk("mid busy", busy, 1);
    s_rst_n = 0;
    repeat (2) @(negedge clk);
    chk("in reset rdy", rdy, 0);
    chk("in reset pkt_cnt", pkt, 0);
    chk("in reset len_err_cnt", errc, 0);
    chk("in reset checksum", cs, 0);
    chk("in reset checksum_vld", csv, 0);
    chk("in reset busy", busy, 0);
    s_rst_n = 1;
    @(negedge clk);
    vld = 1;
    for (int i = 0; i < N; i++) begin
      data = DW'(1 << i);
      last = i == N - 1;
      @(negedge clk);
    end
    vld = 0; last = 0;
    @(negedge clk);
    chk("after reset pkt_cnt", pkt, 1);
    chk("after reset len_err_cnt", errc, 0);
    chk("after reset checksum", cs, CS1);
    chk("after reset busy", busy, 0);
    for (int r = 0; r < 4; r++) begin
      stall_en = 1'($urandom);
      do_reset();
      for (int c = 0; c < 120; c++) begin
        vld = $urandom_range(0, 3) != 0;
        last = $urandom_range(0, 4) == 0;
        data = DW'($urandom);
        if ($urandom_range(0, 15) == 0) stall_en = ~stall_en;
        s_rst_n = $urandom_range(0, 79) != 0;
        @(negedge clk);
      end
      vld = 0; last = 0; s_rst_n = 1;
      @(negedge clk);
    end
    mchk = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
